// File: rtl/cpu_run_controller.sv
// Run controller for the pipelined RISC-V core: loads the program image, sequences the CPU
// reset, runs it, and reports a halt (ebreak) or timeout together with cycle/instret counts.
module cpu_run_controller #(
   parameter int unsigned    XLEN       = 32,
   parameter int unsigned    ADDR_W     = 6,
   parameter int unsigned    CNT_W      = 32,
   parameter int unsigned    RST_CYCLES = 2,
   parameter int unsigned    MAX_CYCLES = 1000,
   parameter logic [XLEN-1:0] HALT_INSTR = 32'h00100073
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [XLEN-1:0]   load_data,
   input  logic              start,
   input  logic              abort,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [XLEN-1:0]   imem_wdata,
   output logic              cpu_reset,
   input  logic              retire_valid,
   input  logic [XLEN-1:0]   retire_instr,
   input  logic [XLEN-1:0]   retire_pc,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [XLEN-1:0]   halt_pc,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  instret
);

   localparam int unsigned RcW = $clog2(RST_CYCLES + 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [RcW-1:0]    rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic [XLEN-1:0]   halt_pc_q, halt_pc_d;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_waddr_q;
   logic [XLEN-1:0]   imem_wdata_q;

   logic              halt_hit;
   logic              load_accept;
   logic [CNT_W-1:0]  cycle_inc;
   logic [CNT_W-1:0]  instret_inc;

   assign load_ready  = (state_q == StIdle) || (state_q == StDone);
   assign busy        = (state_q == StRst) || (state_q == StRun);
   assign cpu_reset   = (state_q != StRun);
   assign load_accept = load_valid && load_ready;
   assign halt_hit    = retire_valid && (retire_instr == HALT_INSTR);
   assign cycle_inc   = (cycle_q == CntMax) ? cycle_q : cycle_q + 1'b1;
   assign instret_inc = (instret_q == CntMax) ? instret_q : instret_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cycle_d   = cycle_q;
      instret_d = instret_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      halt_pc_d = halt_pc_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StRst;
               rst_cnt_d = RcW'(RST_CYCLES);
               done_d    = 1'b0;
               timeout_d = 1'b0;
               halt_pc_d = '0;
               cycle_d   = '0;
               instret_d = '0;
            end
         end
         StRst: begin
            if (abort) begin
               state_d = StIdle;
            end else if (rst_cnt_q == RcW'(1)) begin
               // Last reset cycle: the CPU sees exactly RST_CYCLES cycles of reset.
               state_d   = StRun;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q - 1'b1;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               cycle_d = cycle_inc;
               if (retire_valid) instret_d = instret_inc;
               // Halt takes priority over a timeout landing in the same cycle.
               if (halt_hit) begin
                  state_d   = StDone;
                  done_d    = 1'b1;
                  timeout_d = 1'b0;
                  halt_pc_d = retire_pc;
               end else if (cycle_inc == CNT_W'(MAX_CYCLES)) begin
                  state_d   = StDone;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
                  halt_pc_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         rst_cnt_q    <= '0;
         cycle_q      <= '0;
         instret_q    <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         halt_pc_q    <= '0;
         imem_we_q    <= 1'b0;
         imem_waddr_q <= '0;
         imem_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         halt_pc_q <= halt_pc_d;
         imem_we_q <= load_accept;
         if (load_accept) begin
            imem_waddr_q <= load_addr;
            imem_wdata_q <= load_data;
         end
      end
   end

   assign imem_we     = imem_we_q;
   assign imem_waddr  = imem_waddr_q;
   assign imem_wdata  = imem_wdata_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign halt_pc     = halt_pc_q;
   assign cycle_count = cycle_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: a cycle-by-cycle vector table for load/start/run/halt,
// plus hand sequences for restart, timeout, halt-at-limit, abort and mid-run reset.
module tb_cpu_run_controller;

   localparam logic [31:0] EBREAK = 32'h00100073;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [5:0]  load_addr = '0;
   logic [31:0] load_data = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_instr = '0;
   logic [31:0] retire_pc = '0;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] halt_pc;
   logic [31:0] cycle_count;
   logic [31:0] instret;

   int checks = 0;
   int errors = 0;

   cpu_run_controller #(
      .XLEN(32), .ADDR_W(6), .CNT_W(32), .RST_CYCLES(2), .MAX_CYCLES(10),
      .HALT_INSTR(32'h00100073)
   ) dut (
      .clk(clk), .reset(reset),
      .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
      .load_data(load_data), .start(start), .abort(abort),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset), .retire_valid(retire_valid), .retire_instr(retire_instr),
      .retire_pc(retire_pc), .busy(busy), .done(done), .timeout(timeout),
      .halt_pc(halt_pc), .cycle_count(cycle_count), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic lv; logic [5:0] la; logic [31:0] ld; logic st; logic ab;
      logic rv; logic [31:0] ri; logic [31:0] rp;
      logic e_we; logic [5:0] e_wa; logic [31:0] e_wd;
      logic e_crst; logic e_busy; logic e_lr; logic e_done; logic e_to;
      logic [31:0] e_hpc; logic [31:0] e_cyc; logic [31:0] e_ins;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mkv(input logic lv, input logic [5:0] la, input logic [31:0] ld,
                                input logic st, input logic ab, input logic rv,
                                input logic [31:0] ri, input logic [31:0] rp,
                                input logic we, input logic [5:0] wa, input logic [31:0] wd,
                                input logic crst, input logic bsy, input logic lr,
                                input logic dn, input logic to, input logic [31:0] hpc,
                                input logic [31:0] cyc, input logic [31:0] ins);
      vec_t v;
      v.lv = lv; v.la = la; v.ld = ld; v.st = st; v.ab = ab;
      v.rv = rv; v.ri = ri; v.rp = rp;
      v.e_we = we; v.e_wa = wa; v.e_wd = wd;
      v.e_crst = crst; v.e_busy = bsy; v.e_lr = lr; v.e_done = dn; v.e_to = to;
      v.e_hpc = hpc; v.e_cyc = cyc; v.e_ins = ins;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic crst, input logic bsy,
                              input logic lr, input logic dn, input logic to,
                              input logic [31:0] hpc, input logic [31:0] cyc,
                              input logic [31:0] ins);
      chk({tag, ".cpu_reset"}, 64'(cpu_reset), 64'(crst));
      chk({tag, ".busy"}, 64'(busy), 64'(bsy));
      chk({tag, ".load_ready"}, 64'(load_ready), 64'(lr));
      chk({tag, ".done"}, 64'(done), 64'(dn));
      chk({tag, ".timeout"}, 64'(timeout), 64'(to));
      chk({tag, ".halt_pc"}, 64'(halt_pc), 64'(hpc));
      chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(cyc));
      chk({tag, ".instret"}, 64'(instret), 64'(ins));
   endtask

   task automatic apply_vec(input int i);
      load_valid = vecs[i].lv; load_addr = vecs[i].la; load_data = vecs[i].ld;
      start = vecs[i].st; abort = vecs[i].ab;
      retire_valid = vecs[i].rv; retire_instr = vecs[i].ri; retire_pc = vecs[i].rp;
      tick();
      chk($sformatf("v%0d.imem_we", i), 64'(imem_we), 64'(vecs[i].e_we));
      if (vecs[i].e_we) begin
         chk($sformatf("v%0d.imem_waddr", i), 64'(imem_waddr), 64'(vecs[i].e_wa));
         chk($sformatf("v%0d.imem_wdata", i), 64'(imem_wdata), 64'(vecs[i].e_wd));
      end
      check_state($sformatf("v%0d", i), vecs[i].e_crst, vecs[i].e_busy, vecs[i].e_lr,
                  vecs[i].e_done, vecs[i].e_to, vecs[i].e_hpc, vecs[i].e_cyc, vecs[i].e_ins);
   endtask

   task automatic idle_inputs();
      load_valid = 1'b0; start = 1'b0; abort = 1'b0;
      retire_valid = 1'b0; retire_instr = '0; retire_pc = '0;
   endtask

   // Start pulse plus two reset cycles; leaves the DUT in its first RUN cycle.
   task automatic begin_run(input string tag);
      idle_inputs();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_state({tag, ".rst0"}, 1, 1, 0, 0, 0, 0, 0, 0);
      tick();
      chk({tag, ".rst1.cpu_reset"}, 64'(cpu_reset), 64'(1));
      tick();
      chk({tag, ".run.cpu_reset"}, 64'(cpu_reset), 64'(0));
   endtask

   initial begin
      //              lv la  ld            st ab rv ri    rp        we wa wd
      //              crst busy lr done to hpc cyc ins
      vecs[0]  = mkv(1, 0, 32'h0050_0093, 0, 0, 0, 0, 0, 1, 0, 32'h0050_0093,
                     1, 0, 1, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(1, 1, 32'h0010_0113, 0, 0, 0, 0, 0, 1, 1, 32'h0010_0113,
                     1, 0, 1, 0, 0, 0, 0, 0);
      vecs[2]  = mkv(1, 2, 32'h0020_8193, 0, 0, 0, 0, 0, 1, 2, 32'h0020_8193,
                     1, 0, 1, 0, 0, 0, 0, 0);
      vecs[3]  = mkv(1, 3, 32'h0010_0073, 0, 0, 0, 0, 0, 1, 3, 32'h0010_0073,
                     1, 0, 1, 0, 0, 0, 0, 0);
      vecs[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      vecs[5]  = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      vecs[8]  = mkv(0, 0, 0, 0, 0, 1, NOP, 32'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);
      vecs[9]  = mkv(0, 0, 0, 1, 0, 1, NOP, 32'h04, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 2);
      vecs[10] = mkv(1, 7, 32'hDEAD_BEEF, 0, 0, 1, NOP, 32'h08, 0, 0, 0,
                     0, 1, 0, 0, 0, 0, 3, 3);
      vecs[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 3);
      vecs[12] = mkv(0, 0, 0, 0, 0, 1, EBREAK, 32'h14, 0, 0, 0,
                     1, 0, 1, 1, 0, 32'h14, 5, 4);
      vecs[13] = mkv(0, 0, 0, 0, 1, 1, NOP, 32'h18, 0, 0, 0, 1, 0, 1, 1, 0, 32'h14, 5, 4);

      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      chk("reset.imem_we", 64'(imem_we), 64'(0));
      chk("reset.imem_waddr", 64'(imem_waddr), 64'(0));
      chk("reset.imem_wdata", 64'(imem_wdata), 64'(0));
      check_state("reset", 1, 0, 1, 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Load, start, run to ebreak, then DONE holds
      for (int i = 0; i < 14; i++) apply_vec(i);

      // Restart from DONE replays the loaded image with identical results
      for (int i = 5; i < 13; i++) apply_vec(i);

      // Timeout: retire NOPs every cycle, never ebreak
      begin_run("to");
      retire_valid = 1'b1; retire_instr = NOP;
      for (int c = 1; c < 10; c++) begin
         retire_pc = 32'(c * 4);
         tick();
      end
      check_state("to.c9", 0, 1, 0, 0, 0, 0, 9, 9);
      tick();
      idle_inputs();
      check_state("to.end", 1, 0, 1, 1, 1, 0, 10, 10);

      // ebreak retires in the cycle the limit is reached: halt wins
      begin_run("hm");
      for (int c = 1; c < 10; c++) tick();
      retire_valid = 1'b1; retire_instr = EBREAK; retire_pc = 32'h40;
      tick();
      idle_inputs();
      check_state("hm.end", 1, 0, 1, 1, 0, 32'h40, 10, 1);

      // Abort in RUN after 5 cycles, with start asserted in the same cycle
      begin_run("ab");
      for (int c = 0; c < 5; c++) tick();
      chk("ab.c5.cycle_count", 64'(cycle_count), 64'(5));
      abort = 1'b1; start = 1'b1;
      tick();
      idle_inputs();
      check_state("ab.idle", 1, 0, 1, 0, 0, 0, 5, 0);
      tick();
      check_state("ab.idle2", 1, 0, 1, 0, 0, 0, 5, 0);

      // Abort during RST also returns to IDLE
      start = 1'b1;
      tick();
      start = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      check_state("abrst", 1, 0, 1, 0, 0, 0, 0, 0);

      // Synchronous reset mid-run
      begin_run("rs");
      retire_valid = 1'b1; retire_instr = NOP;
      for (int c = 0; c < 3; c++) tick();
      reset = 1'b1;
      tick();
      idle_inputs();
      reset = 1'b0;
      chk("rs.imem_we", 64'(imem_we), 64'(0));
      check_state("rs", 1, 0, 1, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
